alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the 4-bit combinational ALU. It has a WIDTH-bit datapath and a registered 8-bit flag register. CMP is fully implemented. Two new variable-distance shift ops run as a multi-cycle state machine. It sits between the register file (operand issue) and the write-back stage, and uses valid/ready on both sides.

Parameters:
WIDTH, 4, datapath width in bits (minimum 2).
SHW, $clog2(WIDTH)+1, width of the internal shift-count register.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  operation presented.
in_ready  out  1  block accepts an operation this cycle.
opcode  in  4  operation select.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B, or shift distance for RSHN/LSHN.
out_valid  out  1  result/flags valid.
out_ready  in  1  downstream consumes result.
o  out  WIDTH  registered result.
wb  out  1  result is to be written back.
flags  out  8  flag register: [0]Z [1]C [2]N [3]V [4]EQ [5]NE [6]GT [7]LT.

Behaviour:
- Reset (async, any state, including mid-shift):
  - state=IDLE.
  - o=0, wb=0, out_valid=0, flags=8'h00.
  - In-flight operation is discarded.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready at a rising edge latches opcode, a and b.
- Opcodes:
  - 0001 ADD: a+b.
  - 0010 SUB: a-b.
  - 0011 AND.
  - 0100 ORR.
  - 0101 NOR.
  - 0110 XOR.
  - 0111 RSH: a>>1.
  - 1000 LSH: a<<1.
  - 1001 LDI: b.
  - 1010 ADI: a+b.
  - 1011 RSHN: a>>b, logical.
  - 1100 LSHN: a<<b.
  - 1101 CMP: computes a-b and updates flags only.
  - Others (incl. 0000): NOP; result 0, flags unchanged.
- Arithmetic:
  - Results are truncated to WIDTH bits.
  - SUB/CMP use two's complement.
- wb: 1 for every opcode except CMP and NOP.
- Single-cycle ops (all except RSHN/LSHN with 0<b<WIDTH):
  - IDLE→DONE on accept.
  - out_valid rises in the cycle after accept (latency 1).
- RSHN/LSHN:
  - b==0: result a, C=0, latency 1.
  - b>=WIDTH: result 0, C=0, latency 1.
  - Otherwise IDLE→SHIFT with count=b. Each cycle shifts one bit and decrements count. Leaving SHIFT at count==1 goes to DONE.
  - out_valid rises b+1 cycles after accept.
  - C = last bit shifted out.
- DONE holds o, wb and flags stable until out_ready=1, then moves to IDLE. Back-to-back throughput is therefore one op per 2 cycles minimum.
- Flags are updated on the same edge o is loaded (entry to DONE):
  - Z: result==0. For CMP, Z means a-b==0.
  - N: result MSB.
  - C, ADD/ADI: carry out of bit WIDTH-1.
  - C, SUB/CMP: borrow (a<b, unsigned).
  - C, RSH: a[0]. C, LSH: a[WIDTH-1].
  - C, logic ops and LDI: C=0.
  - V: signed overflow for ADD/ADI/SUB/CMP; 0 otherwise.
  - EQ/NE/GT/LT: written only by SUB and CMP, as unsigned comparisons of a vs b. Held for all other ops.
  - NOP: all flags held.
- in_valid while busy is ignored; upstream must hold its request until in_ready.

Test Plan:
1. WIDTH=4, ADD a=9 b=8 → o=1, wb=1, flags Z=0 C=1 N=0 V=1, out_valid 1 cycle after accept.
2. CMP a=3 b=5 → wb=0, EQ=0 NE=1 GT=0 LT=1 C=1 N=1. Then ADD 1+1 → EQ/NE/GT/LT still 0/1/0/1.
3. LSHN a=4'b0011 b=3 → out_valid exactly 4 cycles after accept, o=4'b1000, C=1. in_ready=0 throughout.
4. RSHN b=0 and b=7 (WIDTH=4) → o=a with C=0, then o=0 with C=0, each with latency 1.
5. Hold out_ready=0 for 5 cycles in DONE while driving a new in_valid → o/flags stable, new op not accepted until 1 cycle after out_ready.
6. Assert rst mid-RSHN (b=3, second shift cycle) → o=0, flags=0, out_valid=0 immediately (async). After release, in_ready=1 and ADD 2+2 yields 4.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with a registered 8-bit flag register.
// Variable-distance shifts (RSHN/LSHN) take one clock per bit through the SHIFT state.
module alu_seq #(
   parameter int WIDTH = 4,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic             wb,
   output logic [7:0]       flags
);

   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_ORR  = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_RSH  = 4'b0111;
   localparam logic [3:0] OP_LSH  = 4'b1000;
   localparam logic [3:0] OP_LDI  = 4'b1001;
   localparam logic [3:0] OP_ADI  = 4'b1010;
   localparam logic [3:0] OP_RSHN = 4'b1011;
   localparam logic [3:0] OP_LSHN = 4'b1100;
   localparam logic [3:0] OP_CMP  = 4'b1101;

   localparam logic [WIDTH-1:0] W_LIM = WIDTH[WIDTH-1:0];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             wb_q;
   logic             dir_q;
   logic [WIDTH-1:0] o_q;
   logic [WIDTH-1:0] sh_q;
   logic [SHW-1:0]   cnt_q;
   logic [7:0]       flags_q;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   dif_ext;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] sh_d;
   logic             c_d;
   logic             v_d;
   logic             wb_d;
   logic             ld_o_d;
   logic             hold_fl_d;
   logic             rel_d;
   logic             multi_d;
   logic             sh_out_d;
   logic [3:0]       rel_fl_d;
   logic [7:0]       flags_d;
   logic [7:0]       sh_flags_d;

   function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

   always_comb begin
      sum_ext   = {1'b0, a} + {1'b0, b};
      dif_ext   = {1'b0, a} - {1'b0, b};
      res_d     = '0;
      c_d       = 1'b0;
      v_d       = 1'b0;
      wb_d      = 1'b1;
      ld_o_d    = 1'b1;
      hold_fl_d = 1'b0;
      rel_d     = 1'b0;
      multi_d   = 1'b0;
      case (opcode)
         OP_ADD, OP_ADI: begin
            res_d = sum_ext[WIDTH-1:0];
            c_d   = sum_ext[WIDTH];
            v_d   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_ext[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            // CMP shares the subtractor but leaves o untouched and is not written back
            res_d  = dif_ext[WIDTH-1:0];
            c_d    = dif_ext[WIDTH];
            v_d    = sub_ovf(a[WIDTH-1], b[WIDTH-1], dif_ext[WIDTH-1]);
            rel_d  = 1'b1;
            wb_d   = (opcode == OP_SUB);
            ld_o_d = (opcode == OP_SUB);
         end
         OP_AND: res_d = a & b;
         OP_ORR: res_d = a | b;
         OP_NOR: res_d = ~(a | b);
         OP_XOR: res_d = a ^ b;
         OP_RSH: begin
            res_d = a >> 1;
            c_d   = a[0];
         end
         OP_LSH: begin
            res_d = a << 1;
            c_d   = a[WIDTH-1];
         end
         OP_LDI: res_d = b;
         OP_RSHN, OP_LSHN: begin
            if (b == '0) begin
               res_d = a;
            end else if (b >= W_LIM) begin
               res_d = '0;
            end else begin
               multi_d = 1'b1;
            end
         end
         default: begin
            wb_d      = 1'b0;
            hold_fl_d = 1'b1;
         end
      endcase

      rel_fl_d = rel_d ? {a < b, a > b, a != b, a == b} : flags_q[7:4];
      flags_d  = hold_fl_d ? flags_q
                           : {rel_fl_d, v_d, res_d[WIDTH-1], c_d, res_d == '0};

      if (dir_q) begin
         sh_d     = {sh_q[WIDTH-2:0], 1'b0};
         sh_out_d = sh_q[WIDTH-1];
      end else begin
         sh_d     = {1'b0, sh_q[WIDTH-1:1]};
         sh_out_d = sh_q[0];
      end
      sh_flags_d = {flags_q[7:4], 1'b0, sh_d[WIDTH-1], sh_out_d, sh_d == '0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         o_q         <= '0;
         wb_q        <= 1'b0;
         flags_q     <= 8'h00;
         sh_q        <= '0;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  if (multi_d) begin
                     state_q <= SHIFT;
                     sh_q    <= a;
                     cnt_q   <= b[SHW-1:0];
                     dir_q   <= (opcode == OP_LSHN);
                  end else begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     wb_q        <= wb_d;
                     flags_q     <= flags_d;
                     if (ld_o_d) begin
                        o_q <= res_d;
                     end
                  end
               end
            end
            SHIFT: begin
               // One bit per clock; the final shift loads o and flags directly
               sh_q  <= sh_d;
               cnt_q <= cnt_q - SHW'(1);
               if (cnt_q == SHW'(1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  o_q         <= sh_d;
                  wb_q        <= 1'b1;
                  flags_q     <= sh_flags_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign o         = o_q;
   assign wb        = wb_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq (WIDTH=4) against an arithmetic reference model.
module tb_alu_seq;

   localparam int W    = 4;
   localparam int MOD  = 16;
   localparam int HALF = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   opcode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] o;
   logic         wb;
   logic [7:0]   flags;

   int           n_vec;
   int           n_miss;

   int           m_o;
   int           m_wb;
   int           m_lat;
   logic [7:0]   m_flags;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .wb        (wb),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int to_signed(input int v);
      return (v >= HALF) ? v - MOD : v;
   endfunction

   // Reference: expected result, write-back, flags and latency from the opcode table
   task automatic model(input int op, input int av, input int bv);
      int  r;
      int  sr;
      bit  c;
      bit  v;
      bit  rel;
      bit  hold;
      c = 0; v = 0; rel = 0; hold = 0; r = 0;
      m_lat = 1;
      m_wb  = (op >= 1 && op <= 12) ? 1 : 0;
      case (op)
         1, 10: begin
            r  = av + bv;
            c  = (r >= MOD);
            sr = to_signed(av) + to_signed(bv);
            v  = (sr >= HALF) || (sr < -HALF);
         end
         2, 13: begin
            r   = av - bv;
            c   = (av < bv);
            sr  = to_signed(av) - to_signed(bv);
            v   = (sr >= HALF) || (sr < -HALF);
            rel = 1;
         end
         3: r = av & bv;
         4: r = av | bv;
         5: r = ~(av | bv);
         6: r = av ^ bv;
         7: begin r = av / 2; c = av % 2; end
         8: begin r = av * 2; c = (av >= HALF); end
         9: r = bv;
         11: begin
            if (bv > 0 && bv < W) begin
               r = av >> bv; c = (av >> (bv - 1)) & 1; m_lat = bv + 1;
            end else r = (bv == 0) ? av : 0;
         end
         12: begin
            if (bv > 0 && bv < W) begin
               r = av << bv; c = (av >> (W - bv)) & 1; m_lat = bv + 1;
            end else r = (bv == 0) ? av : 0;
         end
         default: hold = 1;
      endcase
      r = r & (MOD - 1);
      if (!hold) begin
         if (rel) m_flags[7:4] = {av < bv, av > bv, av != bv, av == bv};
         m_flags[3:0] = {v, r >= HALF, c, r == 0};
      end
      if (op != 13) m_o = r;
   endtask

   // Present one op at a negedge, wait for out_valid and check the result
   task automatic issue(input int op, input int av, input int bv);
      int k;
      k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      check("idle_in_ready", in_ready, 1);
      opcode = op[3:0]; a = av[W-1:0]; b = bv[W-1:0]; in_valid = 1'b1;
      @(posedge clk);
      #1;
      model(op, av, bv);
      in_valid = 1'b0;
      @(negedge clk);
      k = 1;
      while (!out_valid && k < 40) begin
         check("busy_in_ready", in_ready, 0);
         in_valid = 1'($urandom_range(0, 1));
         opcode = 4'($urandom_range(0, 15));
         a = W'($urandom_range(0, 15));
         b = W'($urandom_range(0, 15));
         @(negedge clk);
         k++;
      end
      check("out_valid", out_valid, 1);
      check("latency", k, m_lat);
      check("done_in_ready", in_ready, 0);
      if (op != 13) check("o", o, m_o);
      check("wb", wb, m_wb);
      check("flags", flags, m_flags);
   endtask

   task automatic release_out(input int hold);
      in_valid = 1'b0;
      repeat (hold) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_flags", flags, m_flags);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("released", out_valid, 0);
   endtask

   initial begin
      int op;
      int av;
      int bv;
      n_vec = 0; n_miss = 0;
      m_o = 0; m_wb = 0; m_lat = 1; m_flags = 8'h00;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      opcode = 4'h0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst_o", o, 0);
      check("rst_flags", flags, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_wb", wb, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      issue(1, 9, 8);
      check("t1_o", o, 1);
      check("t1_flags", flags[3:0], 4'b1010);
      release_out(0);

      issue(13, 3, 5);
      check("t2_cmp_flags", flags, 8'b1010_0110);
      release_out(1);
      issue(1, 1, 1);
      check("t2_rel_held", flags[7:4], 4'b1010);
      release_out(0);

      issue(12, 3, 3);
      check("t3_o", o, 8);
      check("t3_c", flags[1], 1);
      release_out(0);

      issue(11, 11, 0);
      check("t4_b0_o", o, 11);
      release_out(0);
      issue(11, 11, 7);
      check("t4_big_o", o, 0);
      release_out(0);

      issue(1, 6, 7);
      in_valid = 1'b1; opcode = 4'd6; a = 4'd5; b = 4'd3;
      repeat (5) begin
         @(negedge clk);
         check("t5_valid", out_valid, 1);
         check("t5_o", o, m_o);
         check("t5_flags", flags, m_flags);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t5_gap_valid", out_valid, 0);
      check("t5_gap_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model(6, 5, 3);
      @(negedge clk);
      check("t5_new_valid", out_valid, 1);
      check("t5_new_o", o, 6);
      check("t5_new_flags", flags, m_flags);
      release_out(0);

      opcode = 4'd11; a = 4'd12; b = 4'd3; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_o", o, 0);
      check("t6_flags", flags, 0);
      check("t6_out_valid", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      m_flags = 8'h00; m_o = 0;
      @(negedge clk);
      check("t6_in_ready", in_ready, 1);
      issue(1, 2, 2);
      check("t6_add", o, 4);
      release_out(0);

      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 15);
         av = $urandom_range(0, 15);
         bv = (op == 11 || op == 12) ? $urandom_range(0, 7) : $urandom_range(0, 15);
         issue(op, av, bv);
         release_out($urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
